// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit
//  Description : Iterative shifter for the multicycle datapath. Takes the
//                operand from the shift-source mux and the amount from the
//                shift-amount path. It shifts one bit position per clock and
//                flags completion with a one-cycle done pulse. The result then
//                goes to the register-file write-back mux.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1        system clock, rising-edge active
//    reset    in   1        synchronous active-high reset
//    start    in   1        request pulse, sampled only while idle
//    op       in   2        00 SLL, 01 SRL, 10 SRA, 11 pass-through
//    data_in  in   WIDTH    operand, latched on an accepted start
//    shamt    in   SHAMT_W  shift amount, latched on an accepted start
//    result   out  WIDTH    registered result, held until next accepted start
//    busy     out  1        high whenever the unit is not idle
//    done     out  1        one-cycle pulse, result is final in that cycle
// ============================================================================
module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] c_OP_SLL  = 2'b00;
    localparam logic [1:0] c_OP_SRL  = 2'b01;
    localparam logic [1:0] c_OP_SRA  = 2'b10;
    localparam logic [1:0] c_OP_PASS = 2'b11;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [SHAMT_W-1:0] c_CNT_ONE = SHAMT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [SHAMT_W-1:0] r_count;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_accept;

    // Only an idle unit accepts a request; start has no effect anywhere else.
    assign w_accept = (r_state == c_ST_IDLE) && start;

    // One-bit step of the latched operation.
    always_comb begin
        w_shifted = r_result;
        case (r_op)
            c_OP_SLL: w_shifted = {r_result[WIDTH-2:0], 1'b0};
            c_OP_SRL: w_shifted = {1'b0, r_result[WIDTH-1:1]};
            c_OP_SRA: w_shifted = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
            default:  w_shifted = r_result;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A zero amount or pass-through skips SHIFT entirely.
    // The unit leaves SHIFT while the count still reads 1, so the counter
    // never reaches zero inside SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if ((shamt == '0) || (op == c_OP_PASS)) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_SHIFT;
                    end
                end
            end
            c_ST_SHIFT: begin
                if (r_count == c_CNT_ONE) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, step while shifting, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_count  <= '0;
            r_op     <= c_OP_SLL;
        end else if (w_accept) begin
            r_result <= data_in;
            r_count  <= shamt;
            r_op     <= op;
        end else if (r_state == c_ST_SHIFT) begin
            r_result <= w_shifted;
            r_count  <= r_count - c_CNT_ONE;
        end
    end

    // Status is a pure decode of the state register, so start has no
    // combinational path to busy or done.
    assign result = r_result;
    assign busy   = (r_state != c_ST_IDLE);
    assign done   = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
